// File: rtl/wb_stage.sv
// wb_stage: write-back stage in front of the register file.
// Buffers MEM results in a small in-order FIFO, retires at most one entry per
// cycle onto the register file write port, and lets decode forward values that
// are still queued here.
// Optional feature macro: WB_INSTRET_EN adds the instret retire counter port.
module wb_stage #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inValid,
    output logic              inReady,
    input  logic              inWReg,
    input  logic [ADDR_W-1:0] inWAddr,
    input  logic [DATA_W-1:0] inWData,
    input  logic              stall,
    output logic              wEnable,
    output logic [ADDR_W-1:0] wAddr,
    output logic [DATA_W-1:0] wData,
    output logic              retire,
    input  logic [ADDR_W-1:0] r1Addr,
    output logic              r1Hit,
    output logic [DATA_W-1:0] r1Fwd,
    input  logic [ADDR_W-1:0] r2Addr,
    output logic              r2Hit,
    output logic [DATA_W-1:0] r2Fwd
`ifdef WB_INSTRET_EN
    ,
    output logic [CNT_W-1:0]  instret
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_QW = $clog2(DEPTH + 1);

    // Pointers wrap naturally only for power-of-two depths.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_param
        $error("wb_stage: DEPTH must be a power of 2 >= 2 and CNT_W >= 1");
    end

    logic              ent_wreg [DEPTH];
    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_QW-1:0] count;

    logic push;
    logic pop;
    logic nonempty;

    // Returns {hit, data} for the youngest valid queued write to address a.
    // Entries are scanned oldest to youngest so a later match overrides.
    function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] a);
        logic [DATA_W:0]  res;
        logic [PTR_W-1:0] idx;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_QW'(i) < count) && ent_wreg[idx] &&
                (ent_addr[idx] == a) && (a != '0)) begin
                res = {1'b1, ent_data[idx]};
            end
        end
        return res;
    endfunction

    // Handshake and write-port decode; accept is blocked while full even if a
    // pop happens in the same cycle, which keeps inReady free of the stall path.
    always_comb begin
        nonempty = (count != '0);
        inReady  = rst_n && (count < CNT_QW'(DEPTH));
        retire   = nonempty && !stall;
        push     = inValid && inReady;
        pop      = retire;
        wAddr    = nonempty ? ent_addr[head] : '0;
        wData    = nonempty ? ent_data[head] : '0;
        wEnable  = retire && ent_wreg[head] && (ent_addr[head] != '0);
    end

    // Forwarding lookup for decode port 1.
    always_comb begin
        {r1Hit, r1Fwd} = fwd_lookup(r1Addr);
    end

    // Forwarding lookup for decode port 2.
    always_comb begin
        {r2Hit, r2Fwd} = fwd_lookup(r2Addr);
    end

    // FIFO control: pointers and occupancy; reset drops all queued entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_wreg[tail] <= inWReg;
            ent_addr[tail] <= inWAddr;
            ent_data[tail] <= inWData;
        end
    end

`ifdef WB_INSTRET_EN
    logic [CNT_W-1:0] instret_q;

    // Retired-instruction counter, including non-writing entries; wraps freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 1'b1;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed table, hand sequences and random stimulus for wb_stage,
// compared against a queue-based model of the write-back FIFO.
module tb_wb_stage;

    localparam int DEPTH  = 2;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              inValid;
    logic              inReady;
    logic              inWReg;
    logic [ADDR_W-1:0] inWAddr;
    logic [DATA_W-1:0] inWData;
    logic              stall;
    logic              wEnable;
    logic [ADDR_W-1:0] wAddr;
    logic [DATA_W-1:0] wData;
    logic              retire;
    logic [ADDR_W-1:0] r1Addr;
    logic              r1Hit;
    logic [DATA_W-1:0] r1Fwd;
    logic [ADDR_W-1:0] r2Addr;
    logic              r2Hit;
    logic [DATA_W-1:0] r2Fwd;
`ifdef WB_INSTRET_EN
    logic [CNT_W-1:0]  instret;
`endif

    always #5 clk = ~clk;

    wb_stage #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .inValid(inValid),
        .inReady(inReady),
        .inWReg (inWReg),
        .inWAddr(inWAddr),
        .inWData(inWData),
        .stall  (stall),
        .wEnable(wEnable),
        .wAddr  (wAddr),
        .wData  (wData),
        .retire (retire),
        .r1Addr (r1Addr),
        .r1Hit  (r1Hit),
        .r1Fwd  (r1Fwd),
        .r2Addr (r2Addr),
        .r2Hit  (r2Hit),
        .r2Fwd  (r2Fwd)
`ifdef WB_INSTRET_EN
        ,
        .instret(instret)
`endif
    );

    typedef struct {
        logic              wreg;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    typedef struct {
        logic              v;
        logic              wr;
        logic [ADDR_W-1:0] ad;
        logic [DATA_W-1:0] dt;
        logic              st;
        logic [ADDR_W-1:0] r1;
        logic [ADDR_W-1:0] r2;
        logic              rdy;
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic              ret;
        logic              h1;
        logic [DATA_W-1:0] f1;
        logic              h2;
        logic [DATA_W-1:0] f2;
    } vec_t;

    ent_t    mq[$];
    longint  n_retired = 0;
    int      checks    = 0;
    int      failures  = 0;
    vec_t    tbl[15];

    function automatic vec_t mk(
        input logic v, input logic wr, input logic [ADDR_W-1:0] ad,
        input logic [DATA_W-1:0] dt, input logic st,
        input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2,
        input logic rdy, input logic we, input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd, input logic ret,
        input logic h1, input logic [DATA_W-1:0] f1,
        input logic h2, input logic [DATA_W-1:0] f2);
        vec_t t;
        t.v = v;   t.wr = wr; t.ad = ad; t.dt = dt; t.st = st; t.r1 = r1; t.r2 = r2;
        t.rdy = rdy; t.we = we; t.wa = wa; t.wd = wd; t.ret = ret;
        t.h1 = h1; t.f1 = f1; t.h2 = h2; t.f2 = f2;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Youngest queued register write to address a, as seen by decode.
    task automatic model_fwd(input logic [ADDR_W-1:0] a, output logic hit, output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != 0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!hit && mq[i].wreg && mq[i].addr == a) begin
                    hit = 1'b1;
                    d   = mq[i].data;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic              m_ret;
        logic              m_we;
        logic              h;
        logic [DATA_W-1:0] f;
        m_ret = (mq.size() != 0) && !stall;
        m_we  = m_ret && mq[0].wreg && (mq[0].addr != 0);
        check({tag, ".inReady"}, inReady, mq.size() < DEPTH);
        check({tag, ".retire"}, retire, m_ret);
        check({tag, ".wEnable"}, wEnable, m_we);
        check({tag, ".wAddr"}, wAddr, (mq.size() != 0) ? mq[0].addr : 0);
        check({tag, ".wData"}, wData, (mq.size() != 0) ? mq[0].data : 0);
        model_fwd(r1Addr, h, f);
        check({tag, ".r1Hit"}, r1Hit, h);
        check({tag, ".r1Fwd"}, r1Fwd, f);
        model_fwd(r2Addr, h, f);
        check({tag, ".r2Hit"}, r2Hit, h);
        check({tag, ".r2Fwd"}, r2Fwd, f);
    endtask

    // Advance one clock and apply the same transfer rules to the model.
    task automatic clock_edge();
        bit   ret;
        bit   acc;
        ent_t e;
        @(posedge clk);
        ret = (mq.size() != 0) && !stall;
        acc = inValid && (mq.size() < DEPTH);
        if (ret) begin
            void'(mq.pop_front());
            n_retired++;
        end
        if (acc) begin
            e.wreg = inWReg;
            e.addr = inWAddr;
            e.data = inWData;
            mq.push_back(e);
        end
        #1;
    endtask

    task automatic step_checked(input string tag);
        #2;
        check_model(tag);
        clock_edge();
    endtask

    task automatic set_in(input logic v, input logic wr, input logic [ADDR_W-1:0] ad,
                          input logic [DATA_W-1:0] dt, input logic st);
        inValid = v;
        inWReg  = wr;
        inWAddr = ad;
        inWData = dt;
        stall   = st;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        //               v  wr ad  dt            st r1  r2   rdy we wa  wd            ret h1 f1            h2 f2
        tbl[0]  = mk(1, 1, 5,  32'hDEADBEEF, 0, 0,  0,   1, 0, 0,  0,            0,  0, 0,            0, 0);
        tbl[1]  = mk(0, 0, 0,  0,            0, 5,  6,   1, 1, 5,  32'hDEADBEEF, 1,  1, 32'hDEADBEEF, 0, 0);
        tbl[2]  = mk(0, 0, 0,  0,            0, 5,  6,   1, 0, 0,  0,            0,  0, 0,            0, 0);
        tbl[3]  = mk(1, 1, 10, 32'h111,      1, 10, 0,   1, 0, 0,  0,            0,  0, 0,            0, 0);
        tbl[4]  = mk(1, 1, 11, 32'h222,      1, 10, 11,  1, 0, 10, 32'h111,      0,  1, 32'h111,      0, 0);
        tbl[5]  = mk(1, 1, 12, 32'h333,      1, 10, 11,  0, 0, 10, 32'h111,      0,  1, 32'h111,      1, 32'h222);
        tbl[6]  = mk(1, 1, 12, 32'h333,      0, 10, 11,  0, 1, 10, 32'h111,      1,  1, 32'h111,      1, 32'h222);
        tbl[7]  = mk(1, 1, 12, 32'h333,      0, 10, 11,  1, 1, 11, 32'h222,      1,  0, 0,            1, 32'h222);
        tbl[8]  = mk(0, 0, 0,  0,            0, 12, 11,  1, 1, 12, 32'h333,      1,  1, 32'h333,      0, 0);
        tbl[9]  = mk(1, 1, 0,  32'h1,        0, 0,  7,   1, 0, 0,  0,            0,  0, 0,            0, 0);
        tbl[10] = mk(1, 0, 7,  32'h2,        0, 0,  7,   1, 0, 0,  32'h1,        1,  0, 0,            0, 0);
        tbl[11] = mk(0, 0, 0,  0,            0, 0,  7,   1, 0, 7,  32'h2,        1,  0, 0,            0, 0);
        tbl[12] = mk(1, 1, 3,  32'hA,        1, 3,  0,   1, 0, 0,  0,            0,  0, 0,            0, 0);
        tbl[13] = mk(1, 1, 3,  32'hB,        1, 3,  0,   1, 0, 3,  32'hA,        0,  1, 32'hA,        0, 0);
        tbl[14] = mk(0, 0, 0,  0,            1, 3,  0,   0, 0, 3,  32'hA,        0,  1, 32'hB,        0, 0);

        rst_n  = 1'b0;
        set_in(0, 0, 0, 0, 0);
        r1Addr = '0;
        r2Addr = '0;

        // Power-on reset: everything low while rst_n is asserted.
        #2;
        check("reset.inReady", inReady, 0);
        check("reset.retire", retire, 0);
        check("reset.wEnable", wEnable, 0);
        check("reset.wAddr", wAddr, 0);
        check("reset.wData", wData, 0);
        check("reset.r1Hit", r1Hit, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("reset_rel.inReady", inReady, 1);
        @(posedge clk);
        #1;

        // Directed table: single write, stall fill, x0/no-write, forwarding.
        for (int i = 0; i < 15; i++) begin
            set_in(tbl[i].v, tbl[i].wr, tbl[i].ad, tbl[i].dt, tbl[i].st);
            r1Addr = tbl[i].r1;
            r2Addr = tbl[i].r2;
            #2;
            check($sformatf("row%0d.inReady", i), inReady, tbl[i].rdy);
            check($sformatf("row%0d.wEnable", i), wEnable, tbl[i].we);
            check($sformatf("row%0d.wAddr", i), wAddr, tbl[i].wa);
            check($sformatf("row%0d.wData", i), wData, tbl[i].wd);
            check($sformatf("row%0d.retire", i), retire, tbl[i].ret);
            check($sformatf("row%0d.r1Hit", i), r1Hit, tbl[i].h1);
            check($sformatf("row%0d.r1Fwd", i), r1Fwd, tbl[i].f1);
            check($sformatf("row%0d.r2Hit", i), r2Hit, tbl[i].h2);
            check($sformatf("row%0d.r2Fwd", i), r2Fwd, tbl[i].f2);
            clock_edge();
        end

        // Reset mid-operation with two entries queued and the write port active.
        set_in(0, 0, 0, 0, 0);
        #2;
        check("midrst_pre.wEnable", wEnable, 1);
        check("midrst_pre.wAddr", wAddr, 3);
        rst_n = 1'b0;
        #1;
        check("midrst.wEnable", wEnable, 0);
        check("midrst.retire", retire, 0);
        check("midrst.wAddr", wAddr, 0);
        check("midrst.wData", wData, 0);
        check("midrst.r1Hit", r1Hit, 0);
        check("midrst.r1Fwd", r1Fwd, 0);
        check("midrst.inReady", inReady, 0);
        mq.delete();
        n_retired = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("midrst_rel.inReady", inReady, 1);
        check("midrst_rel.wEnable", wEnable, 0);
        check("midrst_rel.retire", retire, 0);
        check("midrst_rel.r1Hit", r1Hit, 0);
        @(posedge clk);
        #1;
        check("midrst_after.wEnable", wEnable, 0);
        check("midrst_after.retire", retire, 0);

        // Three retires, the middle one without a register write.
        r1Addr = 5'd1;
        r2Addr = 5'd3;
        set_in(1, 1, 1, 32'h11, 0);
        step_checked("ir0");
        set_in(1, 0, 2, 32'h22, 0);
        step_checked("ir1");
        set_in(1, 1, 3, 32'h33, 0);
        step_checked("ir2");
        set_in(0, 0, 0, 0, 0);
        step_checked("ir3");
        step_checked("ir4");
        check("instret_seq.retired", n_retired, 3);
`ifdef WB_INSTRET_EN
        check("instret_seq.instret", instret, 3);
`endif

        // Random traffic against the queue model.
        for (int c = 0; c < 400; c++) begin
            set_in($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                   ADDR_W'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 9) < 3);
            r1Addr = ADDR_W'($urandom_range(0, 7));
            r2Addr = ADDR_W'($urandom_range(0, 7));
            step_checked($sformatf("rnd%0d", c));
        end
`ifdef WB_INSTRET_EN
        check("rnd.instret", instret, n_retired);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
